// File: rtl/exe_stage_unit_pkg.sv
// Shared constants for the execute stage: ALU commands, shift types, forwarding selects, NZCV bit indices.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package exe_stage_unit_pkg;

   // ALU command encodings
   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   // Register-shift types from shift_operand[6:5]
   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   // Forwarding selects; 2'b11 also falls back to the register file
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Bit positions inside the 4-bit status word {N,Z,C,V}
   localparam int ST_N = 3;
   localparam int ST_Z = 2;
   localparam int ST_C = 1;
   localparam int ST_V = 0;

   // Rotate right by 0..31; a zero amount returns x unchanged
   function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
      logic [63:0] dbl;
      dbl = {x, x} >> n;
      return dbl[31:0];
   endfunction

   // Operand forwarding mux
   function automatic logic [31:0] fwd_mux(input logic [31:0] rf_val,
                                           input logic [31:0] mem_val,
                                           input logic [31:0] wb_val,
                                           input logic [1:0]  sel);
      case (sel)
         FWD_MEM: return mem_val;
         FWD_WB:  return wb_val;
         default: return rf_val;
      endcase
   endfunction

endpackage

// File: rtl/exe_stage_unit_val2_generator.sv
// Second-operand generator: rotated immediate, memory offset, or shifted register.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module val2_generator
   import exe_stage_unit_pkg::*;
(
   input  logic [31:0] rm_i,
   input  logic [11:0] shift_operand_i,
   input  logic        imm_i,
   input  logic        mem_access_i,
   output logic [31:0] val2_o
);

   logic [4:0] sh_amt;
   logic [1:0] sh_type;

   assign sh_amt  = shift_operand_i[11:7];
   assign sh_type = shift_operand_i[6:5];

   // Immediate wins over memory offset, which wins over register shift
   always_comb begin
      val2_o = rm_i;
      if (imm_i) begin
         val2_o = ror32({24'b0, shift_operand_i[7:0]}, {shift_operand_i[11:8], 1'b0});
      end else if (mem_access_i) begin
         val2_o = {20'b0, shift_operand_i};
      end else begin
         case (sh_type)
            SH_LSL:  val2_o = rm_i << sh_amt;
            SH_LSR:  val2_o = rm_i >> sh_amt;
            SH_ASR:  val2_o = 32'($signed(rm_i) >>> sh_amt);
            default: val2_o = ror32(rm_i, sh_amt);
         endcase
      end
   end

endmodule

// File: rtl/exe_stage_unit.sv
// Execute stage: forwarding, Val2, ALU, NZCV register, branch target, EX/MEM register.
// Latency: one cycle to EX/MEM outputs and status; branch_taken/branch_addr are combinational.
// Backpressure: freeze holds every register in the block; reset overrides freeze.
module exe_stage_unit
   import exe_stage_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              wb_en_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              imm_in,
   input  logic              branch_in,
   input  logic              s_in,
   input  logic [3:0]        exe_cmd_in,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] val_rn_in,
   input  logic [DATA_W-1:0] val_rm_in,
   input  logic [11:0]       shift_operand_in,
   input  logic [23:0]       signed_imm_in,
   input  logic [REG_W-1:0]  dest_in,
   input  logic [1:0]        sel_src1,
   input  logic [1:0]        sel_src2,
   input  logic [DATA_W-1:0] mem_fwd_val,
   input  logic [DATA_W-1:0] wb_fwd_val,
   output logic              wb_en_out,
   output logic              mem_read_out,
   output logic              mem_write_out,
   output logic [DATA_W-1:0] alu_res_out,
   output logic [DATA_W-1:0] val_rm_out,
   output logic [REG_W-1:0]  dest_out,
   output logic [3:0]        status,
   output logic              branch_taken,
   output logic [DATA_W-1:0] branch_addr
);

   logic [31:0] op1;
   logic [31:0] rm_fwd;
   logic [31:0] val2;
   logic [31:0] alu_res_d;
   logic [3:0]  status_d;
   logic [3:0]  status_q;
   logic [32:0] sum33;
   logic [31:0] b_eff;
   logic        cin_eff;
   logic        is_arith;
   logic        is_known;

   logic              wb_en_q, mem_read_q, mem_write_q;
   logic [31:0]       alu_res_q, val_rm_q;
   logic [REG_W-1:0]  dest_q;

   assign op1    = fwd_mux(val_rn_in, mem_fwd_val, wb_fwd_val, sel_src1);
   assign rm_fwd = fwd_mux(val_rm_in, mem_fwd_val, wb_fwd_val, sel_src2);

   val2_generator u_val2 (
      .rm_i            (rm_fwd),
      .shift_operand_i (shift_operand_in),
      .imm_i           (imm_in),
      .mem_access_i    (mem_read_in | mem_write_in),
      .val2_o          (val2)
   );

   // Subtraction is done as op1 + ~val2 + carry-in so C comes out as NOT borrow
   always_comb begin
      alu_res_d = '0;
      status_d  = status_q;
      b_eff     = val2;
      cin_eff   = 1'b0;
      is_arith  = 1'b0;
      is_known  = 1'b1;
      case (exe_cmd_in)
         CMD_ADD: begin b_eff = val2;  cin_eff = 1'b0;           is_arith = 1'b1; end
         CMD_ADC: begin b_eff = val2;  cin_eff = status_q[ST_C]; is_arith = 1'b1; end
         CMD_SUB: begin b_eff = ~val2; cin_eff = 1'b1;           is_arith = 1'b1; end
         CMD_SBC: begin b_eff = ~val2; cin_eff = status_q[ST_C]; is_arith = 1'b1; end
         CMD_MOV: alu_res_d = val2;
         CMD_MVN: alu_res_d = ~val2;
         CMD_AND: alu_res_d = op1 & val2;
         CMD_ORR: alu_res_d = op1 | val2;
         CMD_EOR: alu_res_d = op1 ^ val2;
         default: is_known = 1'b0;
      endcase
      sum33 = {1'b0, op1} + {1'b0, b_eff} + {32'b0, cin_eff};
      if (is_arith) begin
         alu_res_d      = sum33[31:0];
         status_d[ST_C] = sum33[32];
         status_d[ST_V] = (op1[31] == b_eff[31]) && (sum33[31] != op1[31]);
      end
      if (is_known) begin
         status_d[ST_N] = alu_res_d[31];
         status_d[ST_Z] = (alu_res_d == 32'b0);
      end
   end

   // Status register: reset, else update on S when not frozen
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q <= '0;
      end else if (!freeze && s_in) begin
         status_q <= status_d;
      end
   end

   // EX/MEM pipeline register: reset, else load every unfrozen cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_en_q     <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         alu_res_q   <= '0;
         val_rm_q    <= '0;
         dest_q      <= '0;
      end else if (!freeze) begin
         wb_en_q     <= wb_en_in;
         mem_read_q  <= mem_read_in;
         mem_write_q <= mem_write_in;
         alu_res_q   <= alu_res_d;
         val_rm_q    <= rm_fwd;
         dest_q      <= dest_in;
      end
   end

   assign wb_en_out     = wb_en_q;
   assign mem_read_out  = mem_read_q;
   assign mem_write_out = mem_write_q;
   assign alu_res_out   = alu_res_q;
   assign val_rm_out    = val_rm_q;
   assign dest_out      = dest_q;
   assign status        = status_q;

   // Branch target is word offset scaled to bytes, relative to PC+4
   assign branch_taken = branch_in;
   assign branch_addr  = pc_in + {{6{signed_imm_in[23]}}, signed_imm_in, 2'b00};

endmodule

// File: doc/exe_stage_unit.md
Name: exe_stage_unit

Overview:
- Execute stage of the 5-stage ARM-subset pipeline; it is the consumer of everything the ID/EX pipeline register emits.
- Internals: operand forwarding muxes, Val2 generator (immediate rotate / register shift / memory offset), ALU, NZCV status register, branch target adder.
- Drives the EX/MEM register outputs, one cycle of latency.
- Returns branch_taken / branch_addr to IF, and uses branch_taken to flush the ID/EX register.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_W, 4, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- freeze  in  1  memory stall; holds all state in this block
- wb_en_in, mem_read_in, mem_write_in, imm_in, branch_in, s_in  in  1 each  control bits from ID/EX register
- exe_cmd_in  in  4  ALU command
- pc_in  in  32  PC+4 of the instruction
- val_rn_in, val_rm_in  in  32 each  register-file operands
- shift_operand_in  in  12  shifter operand field
- signed_imm_in  in  24  branch offset, in words
- dest_in  in  4  destination register
- sel_src1, sel_src2  in  2 each  forwarding select: 00 = register-file value, 01 = mem_fwd_val, 10 = wb_fwd_val, 11 = register-file value
- mem_fwd_val, wb_fwd_val  in  32 each  forwarded results
- wb_en_out, mem_read_out, mem_write_out  out  1 each  registered control to MEM
- alu_res_out  out  32  registered ALU result / memory address
- val_rm_out  out  32  registered store data (after forwarding)
- dest_out  out  4  registered destination
- status  out  4  registered {N,Z,C,V}, read by ID condition check
- branch_taken  out  1  combinational, equals branch_in
- branch_addr  out  32  combinational, pc_in + (sign_extend(signed_imm_in) << 2)

Behaviour:
- Reset: on a clk edge with rst=1, all registered outputs and status go to 0. Reset has priority over freeze.
- Operand selection:
  - op1 = forwarding mux(val_rn_in, sel_src1).
  - rm = forwarding mux(val_rm_in, sel_src2).
- Val2 priority:
  - imm_in=1: {24'b0, shift_operand_in[7:0]} rotated right by 2 × shift_operand_in[11:8].
  - else if mem_read_in or mem_write_in: zero-extend shift_operand_in[11:0].
  - else: rm shifted by amount shift_operand_in[11:7], type [6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - Amount 0 passes rm unchanged for every type.
- ALU commands (ARM carry convention; C = NOT borrow on subtract):
  - 0001 MOV = val2
  - 1001 MVN = ~val2
  - 0010 ADD (also LDR/STR address) = op1 + val2
  - 0011 ADC = op1 + val2 + C
  - 0100 SUB/CMP = op1 − val2
  - 0101 SBC = op1 − val2 − (1 − C)
  - 0110 AND/TST
  - 0111 ORR
  - 1000 EOR
  - Any other code: result 0, flags unchanged.
- Flags:
  - N = result[31].
  - Z = (result == 0).
  - C, V are computed for 0010/0011/0100/0101 only.
  - V = signed overflow of the 33-bit add/sub.
  - Logic and move ops keep the previous C and V.
- Status register: loads the new NZCV at a clk edge when s_in=1, freeze=0 and rst=0. Otherwise it holds.
- EX/MEM outputs: load {wb_en, mem_read, mem_write, alu_res, rm, dest} at every edge when freeze=0, and hold when freeze=1.
- Latency: ALU result is visible on alu_res_out one cycle after the inputs are presented.
- Branch: no ALU side effects are required. A branch instruction still propagates through EX/MEM with wb_en=0 (as supplied).
- Simultaneous freeze and branch_in: branch_taken/branch_addr still drive combinationally. The upstream freeze logic decides whether to use them.
- Arithmetic wraps modulo 2^32. Shift amounts are 0–31; ROR by n uses (n mod 32).

Decomposition:
- Shared package holds:
  - EXE_cmd localparams (CMD_MOV … CMD_EOR)
  - shift-type constants (SH_LSL/LSR/ASR/ROR)
  - forwarding-select constants (FWD_RF/FWD_MEM/FWD_WB)
  - status bit indices (N=3, Z=2, C=1, V=0)
- One combinational sub-module: val2_generator (inputs rm, shift_operand, imm, mem_access; output val2).
- ALU and status register stay in this module.

Test Plan:
- Reset, then ADD: rst=1 for 1 cycle → all outputs 0. Then exe_cmd=0010, imm=1, shift_operand=12'h0FF, val_rn=32'h1, s=1 → next cycle alu_res_out=32'h100 and status=4'b0000.
- Subtract flags: SUB with val_rn=5, val2=5, s=1 → alu_res_out=0, status=4'b0110 (Z=1, C=1). Then ADD 32'h7FFFFFFF+1 with s=1 → alu_res_out=32'h80000000, status=4'b1001.
- Immediate rotate and ASR:
  - imm=1, shift_operand=12'h4FF → val2=32'hFF000000 (MOV).
  - Register ASR with rm=32'h80000000, shift_operand[11:7]=4, [6:5]=10 → MOV result 32'hF8000000.
- Forwarding and status hold:
  - sel_src1=01, mem_fwd_val=32'd10, val_rn=0, ADD imm 3 → alu_res_out=13.
  - sel_src2=10 on STR → val_rm_out equals wb_fwd_val.
  - s=0 → status unchanged.
- Freeze and sync reset:
  - freeze=1 for 3 cycles with changing inputs → all registered outputs and status hold.
  - rst asserted mid-freeze → outputs 0 at the next edge, not asynchronously.
- Branch: pc_in=32'h100, signed_imm=24'hFFFFFE, branch_in=1 → branch_taken=1 and branch_addr=32'h0F8 in the same cycle.
